offset_cal_10b_12b: RTL and testbench
=====================================

// Module: offset_cal_10b_12b
// PURPOSE
//  Offset calibration engine for the 10-bit ADC path. With the ADC input shorted, it
//  averages 2**LOG2_N raw codes and computes the correction word osc = MID_CODE - average.
//  osc is the signed, sign-extended 12-bit word that the offset-correction adder consumes.
//  It sits between the ADC FSM output and the correction adder; the ADC FSM sequences it.
// PARAMETERS
//  LOG2_N    4    log2 of the sample count per calibration (1..8)
//  MID_CODE  512  ideal mid-scale code for a shorted input (0..1023)
// PORTS
//  clk           in   1   system clock; all state updates on the rising edge
//  rst_n         in   1   asynchronous active-low reset
//  start         in   1   request a calibration; sampled only in IDLE
//  clear_cal     in   1   synchronous: forces osc to 0 and sat to 0, and aborts any run
//  sample_valid  in   1   vin carries a new ADC conversion this cycle
//  vin           in   12  raw ADC code; only vin[9:0] is used (unsigned), [11:10] ignored
//  osc           out  12  correction, {{2{c[9]}},c[9:0]}, where c is signed 10-bit
//  busy          out  1   high while state != IDLE
//  done          out  1   one-cycle pulse when a new osc is loaded
//  sat           out  1   the last result was clipped to the 10-bit signed range
// BEHAVIOUR
//  Reset: state=IDLE; acc, cnt, osc, done and sat are all 0.
//   Reset is honoured at any time, including in mid-run; no partial result is kept.
//  FSM states are IDLE, ACC and CALC. busy is combinational from the state.
//  IDLE: on an edge with start=1, acc<=0 and cnt<=0, and the state moves to ACC.
//   A sample_valid in the same cycle as start is NOT accepted.
//  ACC: on each edge with sample_valid=1, acc<=acc+vin[9:0] and cnt<=cnt+1.
//   Gaps in sample_valid are allowed and are simply waited out; start is ignored.
//   When the 2**LOG2_N-th sample is accepted, the state moves to CALC.
//  CALC (exactly one cycle):
//   avg = (acc + 2**(LOG2_N-1)) >> LOG2_N   (round half up)
//   d   = MID_CODE - avg, computed at 12 bits signed; the range is -511..+512
//   d > 511 gives c=511 and sat=1; d < -512 gives c=-512 and sat=1; otherwise c=d, sat=0
//   On the next edge: osc<=sext(c), done<=1 for one cycle, state<=IDLE.
//  Latency: the last sample is captured at edge E. osc, sat and done update at E+1.
//   busy falls after E+1.
//  done is registered and lasts one cycle; start may be asserted during the done cycle.
//  acc width is 10+LOG2_N bits, plus 1 bit for the rounding add; it never overflows.
//  osc holds its last value between runs; a new run does not disturb it until its CALC.
//  clear_cal has priority over all other inputs.
//   It forces osc<=0, sat<=0, done<=0 and state<=IDLE. Accumulated data is discarded.
//  clear_cal with start in the same cycle: clear wins and start is dropped.
// TESTING
//  1. N=16, 16 samples of 500 -> done pulse 1 cycle after the last sample, osc=12'h00C, sat=0.
//  2. 16 samples of 530 -> osc=12'hFEE (-18), sat=0; osc stays stable until the next CALC.
//  3. 16 samples of 0 -> d=512 clips: osc=12'h1FF, sat=1; then 16 samples of 1023 -> osc=12'hE01, sat=0.
//  4. Rounding: 8 samples of 500 then 8 of 501 -> sum=8008, avg=501, osc=12'h00B.
//     Random sample_valid gaps must not change the result.
//  5. start with sample_valid in the same cycle -> that sample is excluded.
//     start in ACC -> ignored; cnt is checked via the done timing.
//  6. rst_n low after sample 7 -> all outputs 0 immediately. A restart yields the correct osc.
//     clear_cal in mid-run -> osc=0, no done pulse, busy=0 on the next cycle.

Source files
------------

// File: rtl/offset_cal_10b_12b.sv
// Offset calibration engine for the 10-bit ADC path.
// With the ADC input shorted, it averages 2**LOG2_N raw codes and loads the signed
// correction osc = MID_CODE - average, clipped to 10-bit signed and sign-extended to 12 bits.
module offset_cal_10b_12b #(
  parameter int LOG2_N   = 4,
  parameter int MID_CODE = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        clear_cal,
  input  logic        sample_valid,
  input  logic [11:0] vin,
  output logic [11:0] osc,
  output logic        busy,
  output logic        done,
  output logic        sat
);

  localparam int N  = 1 << LOG2_N;
  // The extra bit covers the rounding add, so the sum never wraps.
  localparam int AW = 10 + LOG2_N + 1;
  localparam int CW = LOG2_N + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, ACC, CALC} state_t;

  state_t        state;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;

  logic [AW-1:0]      acc_rnd;
  logic [9:0]         avg;
  logic signed [11:0] d;
  logic [9:0]         c;
  logic               c_sat;

  // Only the 10-bit code is meaningful; the top two bits of vin are ignored.
  logic unused_vin;
  assign unused_vin = ^vin[11:10];

  assign busy = (state != IDLE);

  // Round-half-up average, then the offset against mid-scale clipped to 10-bit signed.
  always_comb begin
    acc_rnd = acc + AW'(N / 2);
    avg     = 10'(acc_rnd >> LOG2_N);
    d       = 12'(MID_CODE) - {2'b00, avg};
    c       = d[9:0];
    c_sat   = 1'b0;
    if (d > 12'sd511) begin
      c     = 10'h1FF;
      c_sat = 1'b1;
    end else if (d < -12'sd512) begin
      c     = 10'h200;
      c_sat = 1'b1;
    end
  end

  // Calibration sequencer: clear_cal overrides everything and discards the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      osc   <= '0;
      done  <= 1'b0;
      sat   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear_cal) begin
        state <= IDLE;
        acc   <= '0;
        cnt   <= '0;
        osc   <= '0;
        sat   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // A sample arriving with start belongs to no run and is dropped.
            if (start) begin
              acc   <= '0;
              cnt   <= '0;
              state <= ACC;
            end
          end
          ACC: begin
            if (sample_valid) begin
              acc <= acc + AW'(vin[9:0]);
              cnt <= cnt + CW'(1);
              if (cnt == LAST) state <= CALC;
            end
          end
          CALC: begin
            osc   <= {{2{c[9]}}, c};
            sat   <= c_sat;
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_offset_cal_10b_12b.sv
// Bench for offset_cal_10b_12b: directed and randomized calibration runs, with a
// scoreboard of expected {osc, sat} popped by a monitor on every done pulse.
module tb_offset_cal_10b_12b;

  localparam int LOG2_N = 4;
  localparam int N      = 1 << LOG2_N;
  localparam int MID    = 512;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        clear_cal;
  logic        sample_valid;
  logic [11:0] vin;
  logic [11:0] osc;
  logic        busy;
  logic        done;
  logic        sat;

  offset_cal_10b_12b #(.LOG2_N(LOG2_N), .MID_CODE(MID)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .clear_cal    (clear_cal),
    .sample_valid (sample_valid),
    .vin          (vin),
    .osc          (osc),
    .busy         (busy),
    .done         (done),
    .sat          (sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] osc;
    logic        sat;
  } exp_t;

  exp_t        sbq[$];
  int          samp[N];
  int          checks = 0;
  int          passes = 0;
  logic [11:0] last_osc = '0;
  logic        last_sat = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Reference: mean of the samples rounded half up, offset from mid-scale, clipped.
  function automatic exp_t model();
    exp_t e;
    int   sum, avg, dd;
    sum = 0;
    for (int i = 0; i < N; i++) sum += samp[i] % 1024;
    avg   = (sum + N / 2) / N;
    dd    = MID - avg;
    e.sat = 1'b0;
    if (dd > 511) begin
      dd = 511; e.sat = 1'b1;
    end else if (dd < -512) begin
      dd = -512; e.sat = 1'b1;
    end
    e.osc = 12'(dd);
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("osc", 32'(osc), 32'(e.osc));
        chk("sat", 32'(sat), 32'(e.sat));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < N; i++) samp[i] = v;
  endtask

  // One full calibration run from start through done.
  task automatic run(input int gap_pct, input bit sv_with_start, input bit start_in_acc,
                     input bit timing_chk);
    exp_t e;
    e = model();
    start = 1'b1; sample_valid = sv_with_start; vin = 12'h3FF;
    tick();
    start = 1'b0; sample_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        sample_valid = 1'b0; vin = 12'($urandom);
        tick();
      end
      if (i == N / 2) begin
        chk("osc_held_in_run", 32'(osc), 32'(last_osc));
        chk("busy_in_acc", 32'(busy), 32'd1);
        if (start_in_acc) begin
          start = 1'b1; sample_valid = 1'b0;
          tick();
          start = 1'b0;
        end
      end
      sample_valid = 1'b1;
      vin = {2'($urandom), 10'(samp[i])};
      if (i == N - 1) sbq.push_back(e);
      tick();
    end
    sample_valid = 1'b0; vin = 12'($urandom);
    if (timing_chk) begin
      @(negedge clk);
      chk("calc_done_low", 32'(done), 32'd0);
      chk("calc_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd1);
      chk("busy_fall", 32'(busy), 32'd0);
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      tick();
    end else begin
      repeat (3) tick();
    end
    last_osc = e.osc;
    last_sat = e.sat;
    repeat (2) tick();
    chk("osc_stable", 32'(osc), 32'(last_osc));
    chk("sat_stable", 32'(sat), 32'(last_sat));
  endtask

  // Start a run and feed k samples without finishing it.
  task automatic partial(input int k);
    start = 1'b1; sample_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < k; i++) begin
      sample_valid = 1'b1; vin = 12'($urandom);
      tick();
    end
    sample_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; clear_cal = 1'b0; sample_valid = 1'b0; vin = '0;
    #1;
    chk("rst_osc", 32'(osc), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    fill(500);  run(0, 1'b0, 1'b0, 1'b1);      // 12'h00C
    fill(530);  run(20, 1'b0, 1'b0, 1'b1);     // 12'hFEE
    fill(0);    run(0, 1'b0, 1'b0, 1'b1);      // 12'h1FF, sat

    // clear_cal with start mid-run: osc/sat cleared, run dropped, no done.
    partial(5);
    clear_cal = 1'b1; start = 1'b1; sample_valid = 1'b1;
    tick();
    clear_cal = 1'b0; start = 1'b0; sample_valid = 1'b0;
    @(negedge clk);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_osc", 32'(osc), 32'd0);
    chk("clr_sat", 32'(sat), 32'd0);
    last_osc = '0; last_sat = 1'b0;
    repeat (N + 4) tick();
    chk("clr_osc_hold", 32'(osc), 32'd0);

    fill(1023); run(0, 1'b0, 1'b0, 1'b1);      // 12'hE01
    for (int i = 0; i < N; i++) samp[i] = (i < N / 2) ? 500 : 501;
    run(0, 1'b0, 1'b0, 1'b1);                  // 12'h00B
    run(50, 1'b0, 1'b0, 1'b0);                 // same with gaps
    fill(600);  run(30, 1'b1, 1'b1, 1'b1);     // start+sample excluded, start in ACC ignored

    // Async reset after sample 7.
    partial(7);
    rst_n = 1'b0;
    #1;
    chk("arst_osc", 32'(osc), 32'd0);
    chk("arst_sat", 32'(sat), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    last_osc = '0; last_sat = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    fill(480);  run(10, 1'b0, 1'b0, 1'b1);     // 12'h020

    for (int r = 0; r < 30; r++) begin
      int base;
      base = int'($urandom_range(1023));
      for (int i = 0; i < N; i++) begin
        if (r % 3 == 0) samp[i] = int'($urandom_range(1023));
        else begin
          samp[i] = base + int'($urandom_range(40)) - 20;
          if (samp[i] < 0) samp[i] = 0;
          if (samp[i] > 1023) samp[i] = 1023;
        end
      end
      run(int'($urandom_range(40)), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    repeat (4) tick();
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
